tlc_link_rx: RTL and testbench
==============================

Name: tlc_link_rx

Overview:
- Bit-serial receiver for the inter-intersection timer link.
- Upstream controller sends 7-bit timer values (green duration, seconds) as framed serial words.
- This block deserialises each frame, checks it, and presents a parallel value with a one-cycle valid strobe.
- Its output feeds the downstream traffic-light controller's parallel timer-load input.

Parameters:
- BIT_TICKS, 16, clock cycles per serial bit; even, >=4.
- DATA_W, 7, payload bits per frame.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_en  input  1  receive enable; 0 holds FSM in IDLE.
- rx_line  input  1  serial line; idles high; asynchronous to clock.
- data_out  output  DATA_W  last good payload.
- data_valid  output  1  one-cycle pulse when data_out updates.
- parity_err  output  1  one-cycle pulse on bad parity.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Frame format, in order:
  - start bit (0)
  - DATA_W data bits, LSB first
  - one even-parity bit: the XOR of data and parity bits must be 0
  - one stop bit (1)
- Reset (async, any time, including mid-frame):
  - FSM to IDLE; tick and bit counters to 0; shift register to 0.
  - Both synchroniser flops to 1.
  - data_out=0; data_valid, parity_err, frame_err, busy all 0.
- Synchroniser: two flops on rx_line. The FSM sees only the synced value (rxs); rx_line-to-rxs latency is 2 cycles.
- States: IDLE, START, DATA, PARITY, STOP, BREAK. busy=1 in every state except IDLE.
- IDLE: when rx_en=1 and rxs=0 (cycle T0), go to START with tick=0.
- START: at T0+BIT_TICKS/2, sample rxs.
  - 1: false start; return to IDLE with no flag.
  - 0: go to DATA with tick=0 and bit=0.
- DATA: sample every BIT_TICKS cycles. Shift each sample in LSB-first. After DATA_W samples, go to PARITY.
- PARITY: sample one bit after BIT_TICKS cycles, then go to STOP.
- STOP: sample at T0+BIT_TICKS/2+(DATA_W+2)*BIT_TICKS. On that sampling edge:
  - stop=0: frame_err=1 (takes priority over parity); data_out unchanged; go to BREAK.
  - stop=1 and parity bad: parity_err=1; data_out unchanged; go to IDLE.
  - stop=1 and parity ok: data_out=payload and data_valid=1 on the same edge; go to IDLE.
- Flag visibility: data_valid, parity_err and frame_err are registered. Each is high for exactly the one cycle after the stop sample edge and is never asserted simultaneously with another flag.
- BREAK: wait for rxs=1, then go to IDLE. A line held low never retriggers a frame.
- Back-to-back frames: returning to IDLE at mid-stop lets the next start edge be detected in the second half of the stop bit with no lost frame.
- rx_en: sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- data_out holds its value until the next good frame or a reset.
- Counters:
  - tick: width clog2(BIT_TICKS); wraps to 0 at each sample.
  - bit: width clog2(DATA_W+1).
  - No arithmetic overflow is possible within legal parameters.

Test Plan:
- Good frame: BIT_TICKS=4; send payload 7'd11 (bits 1,1,0,1,0,0,0; parity 1; stop 1) -> data_out=11 and data_valid high 1 cycle, at the clock after T0+2+9*4=T0+38; no error flags.
- Parity error: send payload 7'd45 with parity bit 1 -> parity_err pulse, data_out stays 11, data_valid stays 0.
- Frame error: send payload 7'd10 with stop bit 0, then hold the line low 20 cycles -> one frame_err pulse; FSM in BREAK (busy=1) until the line is high; no second frame.
- False start: 1-cycle low glitch on rx_line -> no flags, busy returns to 0 by T0+BIT_TICKS/2+1, data_out unchanged.
- Back-to-back: frames 7'd60 then 7'd5 with the second start immediately after the stop bit -> two data_valid pulses; data_out=60 then 5.
- Reset mid-frame: assert reset during the DATA state of 7'd99 -> all outputs 0 immediately. A following clean 7'd7 frame is received correctly, and the partial 99 frame never produces data_valid.

Source files
------------

// File: rtl/tlc_link_rx.sv
// tlc_link_rx
// Bit-serial receiver for the inter-intersection timer link. It deserialises
// framed words (start 0, DATA_W data bits LSB first, even parity, stop 1)
// and hands a checked payload to the traffic-light controller's timer-load
// input.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   rx_en      - receive enable, looked at only while idle
//   rx_line    - serial line (idles high, asynchronous to clock)
//   data_out   - last payload that passed both parity and stop checks
//   data_valid - one-cycle pulse when data_out updates
//   parity_err - one-cycle pulse on a parity failure
//   frame_err  - one-cycle pulse on a missing stop bit
//   busy       - high whenever a frame is in progress (any non-idle state)
module tlc_link_rx #(
    parameter int BIT_TICKS = 16,
    parameter int DATA_W    = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_en,
    input  logic              rx_line,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int BIT_W  = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(BIT_TICKS / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                rxs;

    // Two-flop synchroniser; rxs is the only view of the line the FSM uses.
    // Flops reset to 1 so a reset never looks like a start bit.
    assign sync_d = {sync_q[0], rx_line};
    assign rxs    = sync_q[1];

    // All state in one register bank with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic. The START state waits half a bit so every later
    // sample lands mid-bit; each subsequent state waits a full bit period.
    // par_q accumulates the XOR of data and parity bits, so a clean frame
    // leaves it at 0. Flags default low so each is a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (rx_en && !rxs) begin
                    state_d = S_START;
                    shift_d = '0;
                    par_d   = 1'b0;
                end
            end

            S_START: begin
                if (tick_q == TICK_HALF) begin
                    tick_d = '0;
                    bit_d  = '0;
                    // A line back high at mid-start was only a glitch.
                    state_d = rxs ? S_IDLE : S_DATA;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d              = '0;
                    shift_d             = shift_q >> 1;
                    shift_d[DATA_W-1]   = rxs;
                    par_d               = par_q ^ rxs;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_PARITY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    par_d   = par_q ^ rxs;
                    state_d = S_STOP;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_STOP: begin
                // Leaving at mid-stop lets a back-to-back start bit be
                // caught in the second half of this stop bit.
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (!rxs) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else if (par_q) begin
                        perr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end

            S_BREAK: begin
                // A line stuck low must go high before another frame counts.
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_tlc_link_rx.sv
// tb_tlc_link_rx
// Scoreboard bench for tlc_link_rx with BIT_TICKS=4, DATA_W=7. Each frame
// sent pushes its expected flag, data_out value and arrival cycle; a
// monitor pops and compares whenever any flag is raised.
module tb_tlc_link_rx;

    localparam int BT = 4;
    localparam int DW = 7;
    // Cycles from driving the start bit to seeing the flag: 2 sync flops,
    // one edge into START, half a bit, then nine full bits.
    localparam int FLAG_LAT = 3 + BT / 2 + (DW + 2) * BT;

    localparam int K_VALID = 0;
    localparam int K_PERR  = 1;
    localparam int K_FERR  = 2;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic          rx_en   = 1'b0;
    logic          rx_line = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        int kind;
        int data;
        int cyc;
    } exp_t;

    exp_t sbq[$];

    tlc_link_rx #(
        .BIT_TICKS(BT),
        .DATA_W   (DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx_en     (rx_en),
        .rx_line   (rx_line),
        .data_out  (data_out),
        .data_valid(data_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic driveBit(input logic b);
        rx_line = b;
        repeat (BT) @(posedge clock);
        #1;
    endtask

    // Call at 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic par,
                                 input logic stop, input int kind,
                                 input int exp_data);
        exp_t e;
        e.kind = kind;
        e.data = exp_data;
        e.cyc  = cyc + FLAG_LAT;
        sbq.push_back(e);
        driveBit(1'b0);
        for (int i = 0; i < DW; i++) driveBit(d[i]);
        driveBit(par);
        driveBit(stop);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput({name, "_drained"}, sbq.size(), 0);
    endtask

    // Monitor: every raised flag must match the next scoreboard entry.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (data_valid === 1'b1 || parity_err === 1'b1 || frame_err === 1'b1) begin
            if (sbq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_flag: valid=%0b perr=%0b ferr=%0b data_out=%0d, expected no flag",
                         data_valid, parity_err, frame_err, data_out);
            end else begin
                e = sbq.pop_front();
                checkOutput("data_valid", data_valid, e.kind == K_VALID);
                checkOutput("parity_err", parity_err, e.kind == K_PERR);
                checkOutput("frame_err",  frame_err,  e.kind == K_FERR);
                checkOutput("data_out",   data_out,   e.data);
                checkOutput("flag_cycle", cyc,        e.cyc);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_data_out",   data_out,   0);
        checkOutput("rst_data_valid", data_valid, 0);
        checkOutput("rst_parity_err", parity_err, 0);
        checkOutput("rst_frame_err",  frame_err,  0);
        checkOutput("rst_busy",       busy,       0);
        reset = 1'b0;
        rx_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        $display("[TB] good frame 11");
        applyStimulus(7'd11, 1'b1, 1'b1, K_VALID, 11);
        waitDrain("good");
        checkOutput("good_busy", busy, 0);

        $display("[TB] parity error on 45");
        applyStimulus(7'd45, 1'b1, 1'b1, K_PERR, 11);
        waitDrain("perr");
        checkOutput("perr_data_kept", data_out, 11);

        $display("[TB] frame error on 10, line held low");
        applyStimulus(7'd10, 1'b0, 1'b0, K_FERR, 11);
        repeat (20) @(posedge clock);
        #1;
        checkOutput("break_busy", busy, 1);
        waitDrain("ferr");
        rx_line = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("break_exit_busy", busy, 0);

        $display("[TB] false start glitch");
        rx_line = 1'b0;
        @(posedge clock);
        #1;
        rx_line = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("glitch_busy_start", busy, 1);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("glitch_busy_end", busy, 0);
        checkOutput("glitch_data_kept", data_out, 11);

        $display("[TB] rx_en low blocks start");
        rx_en   = 1'b0;
        rx_line = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        checkOutput("rx_en_off_busy", busy, 0);
        rx_line = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        rx_en = 1'b1;

        $display("[TB] back-to-back 60 then 5, rx_en dropped mid-frame");
        fork
            applyStimulus(7'd60, 1'b0, 1'b1, K_VALID, 60);
            begin
                repeat (10) @(posedge clock);
                #1;
                rx_en = 1'b0;
                repeat (10) @(posedge clock);
                #1;
                rx_en = 1'b1;
            end
        join
        applyStimulus(7'd5, 1'b0, 1'b1, K_VALID, 5);
        waitDrain("b2b");

        $display("[TB] reset during frame 99");
        driveBit(1'b0);
        driveBit(1'b1);
        driveBit(1'b1);
        driveBit(1'b0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_data_out",   data_out,   0);
        checkOutput("midrst_data_valid", data_valid, 0);
        checkOutput("midrst_parity_err", parity_err, 0);
        checkOutput("midrst_frame_err",  frame_err,  0);
        checkOutput("midrst_busy",       busy,       0);
        rx_line = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        $display("[TB] clean frame 7 after reset");
        applyStimulus(7'd7, 1'b1, 1'b1, K_VALID, 7);
        waitDrain("post_rst");
        repeat (10) @(posedge clock);
        #1;
        checkOutput("final_data_out", data_out, 7);
        checkOutput("scoreboard_empty", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
